// File: rtl/cv32e40p_multi_sleep_unit.sv
// Multi-domain sleep unit: per-domain clock gate, enable FSM and idle-hysteresis
// counter, plus a shared maskable wake vector and a latched wake-cause record.

module tc_clk_gating (
    input  logic clk_i,
    input  logic en_i,
    input  logic test_en_i,
    output logic clk_o
);

    logic clk_en;

    // Enable is captured while the clock is low so the gated clock never glitches.
    always_latch begin
        if (!clk_i) begin
            clk_en = en_i | test_en_i;
        end
    end

    assign clk_o = clk_i & clk_en;

endmodule

module cv32e40p_multi_sleep_unit #(
    parameter int NUM_DOMAINS = 2,
    parameter int NUM_WAKE    = 4,
    parameter int IDLE_HYST   = 4,
    localparam int CAUSE_W    = (NUM_WAKE > 1) ? $clog2(NUM_WAKE) : 1
) (
    input  logic                   clk_ungated_i,
    input  logic                   rst_n,
    input  logic                   scan_cg_en_i,
    input  logic                   fetch_enable_i,
    output logic                   fetch_enable_o,
    input  logic [NUM_DOMAINS-1:0] busy_i,
    input  logic [NUM_DOMAINS-1:0] sleep_allowed_i,
    input  logic [NUM_WAKE-1:0]    wake_i,
    input  logic [NUM_WAKE-1:0]    wake_en_i,
    input  logic                   wake_cause_clr_i,
    output logic [NUM_DOMAINS-1:0] clk_gated_o,
    output logic [NUM_DOMAINS-1:0] clock_en_o,
    output logic                   core_sleep_o,
    output logic                   wake_valid_o,
    output logic [CAUSE_W-1:0]     wake_cause_o
);

    localparam int CNT_W = (IDLE_HYST > 0) ? $clog2(IDLE_HYST + 1) : 1;
    localparam logic [CNT_W-1:0] HYST_RELOAD = CNT_W'((IDLE_HYST > 0) ? IDLE_HYST - 1 : 0);

    localparam logic [1:0] OFF   = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] IDLE  = 2'd2;
    localparam logic [1:0] GATED = 2'd3;

    logic                   fe_q;
    logic [1:0]             state_q [NUM_DOMAINS];
    logic [1:0]             state_d [NUM_DOMAINS];
    logic [CNT_W-1:0]       cnt_q   [NUM_DOMAINS];
    logic [CNT_W-1:0]       cnt_d   [NUM_DOMAINS];
    logic [NUM_DOMAINS-1:0] domain_idle;
    logic [NUM_DOMAINS-1:0] leave_gated;
    logic [NUM_WAKE-1:0]    wake_masked;
    logic                   wake_any;
    logic                   all_gated;
    logic                   capture;
    logic [CAUSE_W-1:0]     first_wake;
    logic                   wake_valid_q;
    logic [CAUSE_W-1:0]     wake_cause_q;

    assign wake_masked = wake_i & wake_en_i;
    assign wake_any    = |wake_masked;
    assign domain_idle = ~busy_i & sleep_allowed_i & {NUM_DOMAINS{~wake_any}};

    always_ff @(posedge clk_ungated_i or negedge rst_n) begin
        if (!rst_n) begin
            fe_q <= 1'b0;
        end else if (fetch_enable_i) begin
            fe_q <= 1'b1;
        end
    end

    assign fetch_enable_o = fe_q;

    // Per-domain next state; in GATED the enable is combinational so a wake
    // delivers the very edge that ends the waking cycle.
    always_comb begin
        for (int d = 0; d < NUM_DOMAINS; d++) begin
            state_d[d]     = state_q[d];
            cnt_d[d]       = cnt_q[d];
            clock_en_o[d]  = 1'b0;
            leave_gated[d] = 1'b0;
            case (state_q[d])
                OFF: begin
                    if (fe_q) begin
                        state_d[d] = RUN;
                    end
                end
                RUN: begin
                    clock_en_o[d] = 1'b1;
                    if (domain_idle[d]) begin
                        if (IDLE_HYST == 0) begin
                            state_d[d] = GATED;
                        end else begin
                            state_d[d] = IDLE;
                            cnt_d[d]   = HYST_RELOAD;
                        end
                    end
                end
                IDLE: begin
                    clock_en_o[d] = 1'b1;
                    if (!domain_idle[d]) begin
                        state_d[d] = RUN;
                    end else if (cnt_q[d] == '0) begin
                        state_d[d] = GATED;
                    end else begin
                        cnt_d[d] = cnt_q[d] - 1'b1;
                    end
                end
                GATED: begin
                    clock_en_o[d] = wake_any | busy_i[d];
                    if (wake_any | busy_i[d]) begin
                        state_d[d]     = RUN;
                        leave_gated[d] = 1'b1;
                    end
                end
                default: begin
                    state_d[d] = OFF;
                end
            endcase
        end
    end

    always_ff @(posedge clk_ungated_i or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < NUM_DOMAINS; d++) begin
                state_q[d] <= OFF;
                cnt_q[d]   <= '0;
            end
        end else begin
            for (int d = 0; d < NUM_DOMAINS; d++) begin
                state_q[d] <= state_d[d];
                cnt_q[d]   <= cnt_d[d];
            end
        end
    end

    always_comb begin
        all_gated = 1'b1;
        for (int d = 0; d < NUM_DOMAINS; d++) begin
            if (state_q[d] != GATED) begin
                all_gated = 1'b0;
            end
        end
    end

    assign core_sleep_o = fe_q & all_gated & ~(|clock_en_o);

    // Lowest set index wins when several enabled sources fire together.
    always_comb begin
        first_wake = '0;
        for (int i = NUM_WAKE - 1; i >= 0; i--) begin
            if (wake_masked[i]) begin
                first_wake = CAUSE_W'(i);
            end
        end
    end

    assign capture = (|leave_gated) & wake_any & ~wake_valid_q;

    always_ff @(posedge clk_ungated_i or negedge rst_n) begin
        if (!rst_n) begin
            wake_valid_q <= 1'b0;
            wake_cause_q <= '0;
        end else if (capture) begin
            wake_valid_q <= 1'b1;
            wake_cause_q <= first_wake;
        end else if (wake_cause_clr_i) begin
            wake_valid_q <= 1'b0;
        end
    end

    assign wake_valid_o = wake_valid_q;
    assign wake_cause_o = wake_cause_q;

    for (genvar g = 0; g < NUM_DOMAINS; g++) begin : gen_cg
        tc_clk_gating u_cg (
            .clk_i     (clk_ungated_i),
            .en_i      (clock_en_o[g]),
            .test_en_i (scan_cg_en_i),
            .clk_o     (clk_gated_o[g])
        );
    end

endmodule

// File: tb/tb_cv32e40p_multi_sleep_unit.sv
// Scoreboard bench for cv32e40p_multi_sleep_unit: directed sleep/wake sequences
// followed by randomized traffic, checked against an idle-streak reference model.

module tb_cv32e40p_multi_sleep_unit;

    localparam int ND = 2;
    localparam int NW = 4;
    localparam int H  = 4;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          scan_cg_en;
    logic          fetch_enable_in;
    logic          fetch_enable_out;
    logic [ND-1:0] busy;
    logic [ND-1:0] sleep_allowed;
    logic [NW-1:0] wake;
    logic [NW-1:0] wake_en;
    logic          wake_cause_clr;
    logic [ND-1:0] clk_gated;
    logic [ND-1:0] clock_en;
    logic          core_sleep;
    logic          wake_valid;
    logic [CW-1:0] wake_cause;

    always #5 clk = ~clk;

    cv32e40p_multi_sleep_unit #(
        .NUM_DOMAINS (ND),
        .NUM_WAKE    (NW),
        .IDLE_HYST   (H)
    ) dut (
        .clk_ungated_i    (clk),
        .rst_n            (rst_n),
        .scan_cg_en_i     (scan_cg_en),
        .fetch_enable_i   (fetch_enable_in),
        .fetch_enable_o   (fetch_enable_out),
        .busy_i           (busy),
        .sleep_allowed_i  (sleep_allowed),
        .wake_i           (wake),
        .wake_en_i        (wake_en),
        .wake_cause_clr_i (wake_cause_clr),
        .clk_gated_o      (clk_gated),
        .clock_en_o       (clock_en),
        .core_sleep_o     (core_sleep),
        .wake_valid_o     (wake_valid),
        .wake_cause_o     (wake_cause)
    );

    typedef struct packed {
        logic [ND-1:0] en;
        logic          fe;
        logic          sleep;
        logic          valid;
        logic [CW-1:0] cause;
        logic          scan;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: a domain gates after H+1 consecutive idle cycles.
    bit fe_m;
    bit started_m [ND];
    bit gated_m   [ND];
    int streak_m  [ND];
    bit valid_m;
    int cause_m;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input bit rst, input bit fe, input logic [ND-1:0] b,
                                 input logic [ND-1:0] allow, input logic [NW-1:0] w,
                                 input logic [NW-1:0] wen, input bit clr, input bit scan);
        exp_t          e;
        logic [NW-1:0] m;
        bit            wany;
        bit            any_gated;
        bit            started_next;
        int            low;
        @(negedge clk);
        rst_n           = !rst;
        fetch_enable_in = fe;
        busy            = b;
        sleep_allowed   = allow;
        wake            = w;
        wake_en         = wen;
        wake_cause_clr  = clr;
        scan_cg_en      = scan;
        if (rst) begin
            fe_m    = 0;
            valid_m = 0;
            cause_m = 0;
            for (int d = 0; d < ND; d++) begin
                started_m[d] = 0;
                gated_m[d]   = 0;
                streak_m[d]  = 0;
            end
        end
        m    = w & wen;
        wany = (m != 0);
        low  = 0;
        for (int i = NW - 1; i >= 0; i--) if (m[i]) low = i;
        any_gated = 0;
        e.sleep   = fe_m;
        for (int d = 0; d < ND; d++) begin
            if (!started_m[d])     e.en[d] = 1'b0;
            else if (!gated_m[d])  e.en[d] = 1'b1;
            else                   e.en[d] = wany | b[d];
            if (!gated_m[d]) e.sleep = 1'b0;
            if (gated_m[d]) any_gated = 1;
        end
        if (e.en != 0) e.sleep = 1'b0;
        e.fe    = fe_m;
        e.valid = valid_m;
        e.cause = CW'(cause_m);
        e.scan  = scan;
        sb.push_back(e);
        if (!rst) begin
            for (int d = 0; d < ND; d++) begin
                if (!started_m[d]) begin
                    started_next = fe_m;
                    started_m[d] = started_next;
                end else if (gated_m[d]) begin
                    if (e.en[d]) begin
                        gated_m[d]  = 0;
                        streak_m[d] = 0;
                    end
                end else if (!b[d] && allow[d] && !wany) begin
                    streak_m[d]++;
                    if (streak_m[d] >= H + 1) begin
                        gated_m[d]  = 1;
                        streak_m[d] = 0;
                    end
                end else begin
                    streak_m[d] = 0;
                end
            end
            if (!valid_m && wany && any_gated) begin
                valid_m = 1;
                cause_m = low;
            end else if (clr) begin
                valid_m = 0;
            end
            fe_m = fe_m | fe;
        end
    endtask

    // Monitor: outputs are compared mid-cycle, the gated clocks just after the rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checkOutput("clock_en", 32'(clock_en), 32'(e.en));
                checkOutput("fetch_enable", 32'(fetch_enable_out), 32'(e.fe));
                checkOutput("core_sleep", 32'(core_sleep), 32'(e.sleep));
                checkOutput("wake_valid", 32'(wake_valid), 32'(e.valid));
                checkOutput("wake_cause", 32'(wake_cause), 32'(e.cause));
                @(posedge clk);
                #1;
                checkOutput("clk_gated", 32'(clk_gated), 32'(e.en | {ND{e.scan}}));
            end
        end
    end

    initial begin
        logic [ND-1:0] b;
        logic [ND-1:0] allow;
        logic [NW-1:0] w;
        logic [NW-1:0] wen;
        bit            quiet;
        scan_cg_en      = 0;
        fetch_enable_in = 0;
        busy            = '1;
        sleep_allowed   = '1;
        wake            = '0;
        wake_en         = '0;
        wake_cause_clr  = 0;

        repeat (2) applyStimulus(1, 0, 2'b11, 2'b11, 4'b0000, 4'b0000, 0, 0);
        applyStimulus(0, 0, 2'b11, 2'b11, 4'b0000, 4'b0000, 0, 0);
        applyStimulus(0, 1, 2'b11, 2'b11, 4'b0000, 4'b0000, 0, 0);
        repeat (4) applyStimulus(0, 0, 2'b11, 2'b11, 4'b0000, 4'b0000, 0, 0);
        repeat (8) applyStimulus(0, 0, 2'b10, 2'b11, 4'b0000, 4'b0000, 0, 0);
        repeat (2) applyStimulus(0, 0, 2'b11, 2'b11, 4'b0000, 4'b0000, 0, 0);
        applyStimulus(0, 0, 2'b10, 2'b11, 4'b0000, 4'b0000, 0, 0);
        applyStimulus(0, 0, 2'b10, 2'b11, 4'b0000, 4'b0000, 0, 0);
        applyStimulus(0, 0, 2'b11, 2'b11, 4'b0000, 4'b0000, 0, 0);
        repeat (8) applyStimulus(0, 0, 2'b10, 2'b11, 4'b0000, 4'b0000, 0, 0);
        repeat (10) applyStimulus(0, 0, 2'b00, 2'b11, 4'b0000, 4'b0000, 0, 0);
        repeat (2) applyStimulus(0, 0, 2'b00, 2'b11, 4'b0001, 4'b1110, 0, 0);
        applyStimulus(0, 0, 2'b00, 2'b11, 4'b1100, 4'b1000, 0, 0);
        repeat (7) applyStimulus(0, 0, 2'b00, 2'b11, 4'b0000, 4'b0000, 0, 0);
        applyStimulus(0, 0, 2'b00, 2'b11, 4'b0000, 4'b0000, 1, 0);
        applyStimulus(0, 0, 2'b00, 2'b11, 4'b0010, 4'b1111, 1, 0);
        repeat (7) applyStimulus(0, 0, 2'b00, 2'b11, 4'b0000, 4'b0000, 0, 1);
        repeat (2) applyStimulus(1, 0, 2'b00, 2'b11, 4'b0000, 4'b0000, 0, 0);
        applyStimulus(0, 1, 2'b00, 2'b11, 4'b0000, 4'b0000, 0, 0);

        quiet = 1;
        for (int c = 0; c < 800; c++) begin
            if (c % 24 == 0) quiet = ($urandom_range(0, 2) != 0);
            for (int d = 0; d < ND; d++) begin
                b[d]     = quiet ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 1) == 0);
                allow[d] = ($urandom_range(0, 9) != 0);
            end
            w   = ($urandom_range(0, 11) == 0) ? NW'($urandom) : '0;
            wen = NW'($urandom);
            applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 9) == 0, b, allow, w, wen,
                          $urandom_range(0, 7) == 0, $urandom_range(0, 19) == 0);
        end

        for (int k = 0; k < 20 && sb.size() != 0; k++) @(posedge clk);
        repeat (2) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain actual=%0d expected=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("[TB] FAIL timeout actual=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
